ro_freq_meter: RTL and testbench
================================

Name: ro_freq_meter

Overview:
- Downstream consumer of the ring-oscillator array. It gates one selected oscillator output, counts its edges over a fixed window of system-clock cycles, and reports the count.
- Drives the oscillator enable itself, so a measurement is: enable, settle, count, report.
- One instance per oscillator tap (out3, out101, out1001, ...). Results feed frequency/jitter characterisation logic.

Parameters:
- COUNT_W, 24, width of the measurement count and saturation limit.
- GATE_CYCLES, 1000, measurement window length in clk cycles (>=2).
- WARMUP_CYCLES, 16, clk cycles between raising ro_en and opening the gate (>=1).
- DIV_LOG2, 0, prescaler in the ro_in domain; ro_in is divided by 2^DIV_LOG2 before synchronisation (0 = no divider).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a measurement.
- ro_in  input  1  raw oscillator output, asynchronous to clk.
- ro_en  output  1  enable to the oscillator.
- busy  output  1  high from accepted start until return to IDLE.
- meas_valid  output  1  one-cycle pulse: meas_count/meas_ovf updated.
- meas_count  output  COUNT_W  prescaled rising-edge count of the last window.
- meas_ovf  output  1  last window saturated.

Behaviour:
- Reset (async, rst=1): state=IDLE; ro_en=0, busy=0, meas_valid=0, meas_count=0, meas_ovf=0. Prescaler, synchroniser and counters cleared. Reset mid-measurement aborts with no meas_valid.
- Prescaler: ripple/toggle counter clocked by ro_in, async-cleared by rst or !ro_en. Its MSB (or ro_in itself when DIV_LOG2=0) goes to the clk domain.
- Synchroniser: 2-FF plus one edge-detect FF. A rising edge is detected when sync=1 and prev=0. Max measurable prescaled frequency is below clk/2; above that, results are undefined.
- FSM:
  - IDLE: ro_en=0. start=1 goes to WARMUP, sets busy=1 and ro_en=1 on the next edge. start while busy is ignored.
  - WARMUP: count WARMUP_CYCLES clk cycles, then MEASURE. The edge counter is cleared on entry to MEASURE.
  - MEASURE: exactly GATE_CYCLES cycles. Each detected rising edge increments the counter. The counter saturates at 2^COUNT_W-1 and sets the internal ovf flag; further edges are ignored.
  - DONE: single cycle. Latches the counter to meas_count and ovf to meas_ovf, pulses meas_valid=1, then goes to IDLE (ro_en=0, busy=0 the following cycle).
- Latency: meas_valid asserts WARMUP_CYCLES+GATE_CYCLES+1 cycles after the cycle in which start is sampled.
- meas_count/meas_ovf hold their value until the next DONE.
- An edge detected in the last MEASURE cycle is counted. An edge in the DONE cycle is not.
- start asserted in the DONE cycle is ignored.

Optional Feature:
- Macro RO_FREQ_CONTINUOUS_EN.
- Defined: adds input port cont (1 bit). When cont=1, DONE goes directly back to MEASURE (counter cleared, ro_en stays 1, busy stays 1, no warm-up). meas_valid pulses once per window, every GATE_CYCLES+1 cycles. Clearing cont lets the current window finish, then the FSM goes to IDLE.
- Undefined: no cont port; single-shot only.

Test Plan:
- Bench conditions: clk period 10 ns, DIV_LOG2=0, GATE_CYCLES=1000, WARMUP_CYCLES=16.
- Basic: ro_in behavioural 40 ns clock, start pulse -> meas_valid exactly 1017 cycles after start; meas_count in 249..251; meas_ovf=0; ro_en high only between start+1 and DONE+1.
- Overflow: COUNT_W=6, ro_in period 30 ns -> meas_count=63, meas_ovf=1. A following run with ro_in period 400 ns -> meas_count in 24..26, meas_ovf=0.
- Prescaler: DIV_LOG2=3, ro_in period 5 ns (above clk/2 raw) -> meas_count in 249..251.
- Reset mid-operation: rst pulsed 300 cycles into MEASURE -> all outputs 0 immediately, no meas_valid. A new start afterwards completes normally.
- Start handling: start re-asserted during WARMUP, MEASURE and DONE -> ignored, exactly one meas_valid. ro_in held at 0 -> meas_count=0.
- Continuous (macro defined): cont=1, ro_in 40 ns -> meas_valid every 1001 cycles with counts 249..251. Drop cont mid-window -> one more meas_valid, then busy=0 and ro_en=0.

Source files
------------

// File: rtl/ro_freq_meter.sv
// ro_freq_meter: gates one ring-oscillator tap, counts its prescaled rising
// edges over GATE_CYCLES clk cycles and reports the count.
// Measurement sequence: enable oscillator, warm up, count, report.
// Optional macro RO_FREQ_CONTINUOUS_EN adds a `cont` input. When cont is high,
// windows repeat back to back with no warm-up between them.
module ro_freq_meter #(
  parameter int COUNT_W       = 24,
  parameter int GATE_CYCLES   = 1000,
  parameter int WARMUP_CYCLES = 16,
  parameter int DIV_LOG2      = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef RO_FREQ_CONTINUOUS_EN
  input  logic               cont,
`endif
  input  logic               ro_in,
  output logic               ro_en,
  output logic               busy,
  output logic               meas_valid,
  output logic [COUNT_W-1:0] meas_count,
  output logic               meas_ovf
);

  localparam int TMR_MAX = (GATE_CYCLES > WARMUP_CYCLES) ? GATE_CYCLES : WARMUP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0]   WARM_LAST = TMR_W'(WARMUP_CYCLES - 1);
  localparam logic [TMR_W-1:0]   GATE_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_MEASURE, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr;
  logic [COUNT_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_ro_en, r_busy, r_meas_valid, r_meas_ovf;
  logic [COUNT_W-1:0] r_meas_count;
  logic               r_sync1, r_sync2, r_prev;
  logic               w_ro_div, w_edge, w_cnt_sat, w_cont;

`ifdef RO_FREQ_CONTINUOUS_EN
  assign w_cont = cont;
`else
  assign w_cont = 1'b0;
`endif

  // Prescaler in the oscillator domain. It is held cleared while the
  // oscillator is disabled, so every window starts from the same phase.
  generate
    if (DIV_LOG2 == 0) begin : g_nodiv
      assign w_ro_div = ro_in;
    end else begin : g_div
      logic                w_pre_clr;
      logic [DIV_LOG2-1:0] r_div;
      assign w_pre_clr = rst | ~r_ro_en;
      // Toggle counter clocked by the raw oscillator output.
      always_ff @(posedge ro_in or posedge w_pre_clr) begin
        if (w_pre_clr) r_div <= '0;
        else           r_div <= r_div + 1'b1;
      end
      assign w_ro_div = r_div[DIV_LOG2-1];
    end
  endgenerate

  // Two-FF synchroniser into clk, plus one FF of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= w_ro_div;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_prev;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic. A start is accepted only in IDLE; any other state
  // ignores it, including DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)              w_state_nxt = S_WARMUP;
      S_WARMUP:  if (r_tmr == WARM_LAST) w_state_nxt = S_MEASURE;
      S_MEASURE: if (r_tmr == GATE_LAST) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = w_cont ? S_MEASURE : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Cycle timer. It restarts at every state change, so it counts
  // warm-up cycles and gate cycles separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_tmr <= '0;
    else if (w_state_nxt != r_state || r_state == S_IDLE) r_tmr <= '0;
    else                                             r_tmr <= r_tmr + 1'b1;
  end

  // Saturating edge count. The value is combinational so that an edge seen
  // in the last gate cycle still reaches the latched result.
  always_comb begin
    w_cnt_sat = (r_cnt == CNT_MAX);
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (w_edge) begin
      if (w_cnt_sat) w_ovf_nxt = 1'b1;
      else           w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // The counter runs only in MEASURE. It is cleared in every other state,
  // so each entry to MEASURE starts from zero and edges in DONE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state != S_MEASURE) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Result registers. They are loaded on entry to DONE, so meas_valid is
  // high exactly during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas_valid <= 1'b0;
      r_meas_count <= '0;
      r_meas_ovf   <= 1'b0;
    end else if (r_state == S_MEASURE && w_state_nxt == S_DONE) begin
      r_meas_valid <= 1'b1;
      r_meas_count <= w_cnt_nxt;
      r_meas_ovf   <= w_ovf_nxt;
    end else begin
      r_meas_valid <= 1'b0;
    end
  end

  // Registered enable and busy, decoded from the next state. This keeps
  // ro_en glitch-free, which matters because it also clears the prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ro_en <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ro_en <= (w_state_nxt != S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign ro_en      = r_ro_en;
  assign busy       = r_busy;
  assign meas_valid = r_meas_valid;
  assign meas_count = r_meas_count;
  assign meas_ovf   = r_meas_ovf;

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: directed bench with three instances.
//   u0: default config (COUNT_W=24, DIV_LOG2=0)
//   u1: COUNT_W=6 (saturation)
//   u2: DIV_LOG2=3 (prescaler)
// Each instance has its own behavioural oscillator.
`timescale 1ns/1ps
module tb_ro_freq_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start = '0;
`ifdef RO_FREQ_CONTINUOUS_EN
  logic       cont = 1'b0;
  logic       cont_off = 1'b0;
`endif
  real        ha0, ha1, ha2;
  logic       ro0 = 1'b0, ro1 = 1'b0, ro2 = 1'b0;

  logic        en0, en1, en2, bsy0, bsy1, bsy2, mv0, mv1, mv2, ov0, ov1, ov2;
  logic [23:0] cnt0, cnt2;
  logic [5:0]  cnt1;
  wire  [2:0]  en  = {en2, en1, en0};
  wire  [2:0]  bsy = {bsy2, bsy1, bsy0};
  wire  [2:0]  mv  = {mv2, mv1, mv0};
  wire  [2:0]  ov  = {ov2, ov1, ov0};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural oscillators. A half-period of 0 holds the output low.
  always begin
    if (ha0 == 0.0) begin ro0 = 1'b0; #1; end
    else begin #(ha0); ro0 = ~ro0; end
  end
  always begin
    if (ha1 == 0.0) begin ro1 = 1'b0; #1; end
    else begin #(ha1); ro1 = ~ro1; end
  end
  always begin
    if (ha2 == 0.0) begin ro2 = 1'b0; #1; end
    else begin #(ha2); ro2 = ~ro2; end
  end

  ro_freq_meter u0 (
    .clk(clk), .rst(rst), .start(start[0]),
`ifdef RO_FREQ_CONTINUOUS_EN
    .cont(cont),
`endif
    .ro_in(ro0), .ro_en(en0), .busy(bsy0), .meas_valid(mv0),
    .meas_count(cnt0), .meas_ovf(ov0));

  ro_freq_meter #(.COUNT_W(6)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
`ifdef RO_FREQ_CONTINUOUS_EN
    .cont(cont_off),
`endif
    .ro_in(ro1), .ro_en(en1), .busy(bsy1), .meas_valid(mv1),
    .meas_count(cnt1), .meas_ovf(ov1));

  ro_freq_meter #(.DIV_LOG2(3)) u2 (
    .clk(clk), .rst(rst), .start(start[2]),
`ifdef RO_FREQ_CONTINUOUS_EN
    .cont(cont_off),
`endif
    .ro_in(ro2), .ro_en(en2), .busy(bsy2), .meas_valid(mv2),
    .meas_count(cnt2), .meas_ovf(ov2));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  function automatic int in_rng(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  // One start pulse, then wait for meas_valid.
  // lat counts from the cycle in which start is high. If poke is set, start is
  // re-asserted during WARMUP, MEASURE and DONE. The *_after outputs are
  // sampled one cycle after the DONE cycle.
  task automatic measure(input int sel, input bit poke, output int lat,
                         output int cnt, output int ovf_o, output int en_s1,
                         output int en_after, output int bsy_after,
                         output int mv_after);
    lat = 0;
    @(negedge clk); start[sel] = 1'b1;
    @(negedge clk); start[sel] = 1'b0;
    en_s1 = int'(en[sel]);
    for (int n = 1; n <= 1200; n++) begin
      if (mv[sel]) begin lat = n; break; end
      start[sel] = poke && (n == 5 || n == 500);
      @(negedge clk);
    end
    cnt = cnt_of(sel);
    ovf_o = int'(ov[sel]);
    start[sel] = poke;
    @(negedge clk);
    start[sel] = 1'b0;
    mv_after  = int'(mv[sel]);
    en_after  = int'(en[sel]);
    bsy_after = int'(bsy[sel]);
  endtask

  // Count negedges until meas_valid is seen (0 means none within the bound).
  task automatic wait_mv(input int sel, input int bound, output int n_out);
    n_out = 0;
    for (int n = 1; n <= bound; n++) begin
      @(negedge clk);
      if (mv[sel]) begin n_out = n; break; end
    end
  endtask

  initial begin
    int lat, c, o, e1, ea, ba, ma, n_mv;
    ha0 = 20.0; ha1 = 15.0; ha2 = 2.5;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ro_en", en0, 0);
    chk("rst_busy", bsy0, 0);
    chk("rst_valid", mv0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_ovf", ov0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic measurement: 40 ns oscillator over a 10 us window.
    measure(0, 1'b0, lat, c, o, e1, ea, ba, ma);
    chk("basic_lat", lat, 1017);
    chk("basic_cnt_249_251", in_rng(c, 249, 251), 1);
    chk("basic_ovf", o, 0);
    chk("basic_en_start1", e1, 1);
    chk("basic_valid_pulse", ma, 0);
    chk("basic_en_done1", ea, 0);
    chk("basic_busy_done1", ba, 0);
    chk("basic_cnt_hold", cnt0, c);

    // Reset 300 cycles into MEASURE.
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (316) @(negedge clk);
    chk("mid_busy_pre", bsy0, 1);
    rst = 1'b1;
    #1;
    chk("mid_ro_en", en0, 0);
    chk("mid_busy", bsy0, 0);
    chk("mid_valid", mv0, 0);
    chk("mid_count", cnt0, 0);
    chk("mid_ovf", ov0, 0);
    @(negedge clk); rst = 1'b0;
    wait_mv(0, 1100, n_mv);
    chk("mid_no_valid", n_mv, 0);
    measure(0, 1'b0, lat, c, o, e1, ea, ba, ma);
    chk("after_rst_lat", lat, 1017);
    chk("after_rst_cnt_249_251", in_rng(c, 249, 251), 1);

    // Start re-asserted in WARMUP, MEASURE and DONE; oscillator held at 0.
    ha0 = 0.0;
    repeat (5) @(negedge clk);
    measure(0, 1'b1, lat, c, o, e1, ea, ba, ma);
    chk("poke_lat", lat, 1017);
    chk("poke_cnt_zero", c, 0);
    chk("poke_ovf", o, 0);
    chk("poke_busy_done1", ba, 0);
    wait_mv(0, 1100, n_mv);
    chk("poke_single_valid", n_mv, 0);
    chk("poke_idle_busy", bsy0, 0);

    // Saturation on a 6-bit counter, then a slow oscillator clears overflow.
    measure(1, 1'b0, lat, c, o, e1, ea, ba, ma);
    chk("ovf_lat", lat, 1017);
    chk("ovf_cnt", c, 63);
    chk("ovf_flag", o, 1);
    ha1 = 200.0;
    repeat (5) @(negedge clk);
    measure(1, 1'b0, lat, c, o, e1, ea, ba, ma);
    chk("slow_cnt_24_26", in_rng(c, 24, 26), 1);
    chk("slow_ovf", o, 0);

    // Prescaler: 5 ns raw oscillator divided by 8.
    measure(2, 1'b0, lat, c, o, e1, ea, ba, ma);
    chk("div_lat", lat, 1017);
    chk("div_cnt_249_251", in_rng(c, 249, 251), 1);
    chk("div_ovf", o, 0);

`ifdef RO_FREQ_CONTINUOUS_EN
    // Continuous windows every GATE_CYCLES+1; dropping cont ends after one more window.
    ha0 = 20.0;
    cont = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    wait_mv(0, 1200, n_mv);
    chk("cont_first_lat", n_mv + 1, 1017);
    for (int w = 0; w < 2; w++) begin
      wait_mv(0, 1200, n_mv);
      chk("cont_period", n_mv, 1001);
      chk("cont_cnt_249_251", in_rng(int'(cnt0), 249, 251), 1);
      chk("cont_busy", bsy0, 1);
    end
    repeat (500) @(negedge clk);
    cont = 1'b0;
    wait_mv(0, 1200, n_mv);
    chk("cont_last_period", n_mv, 501);
    chk("cont_last_cnt_249_251", in_rng(int'(cnt0), 249, 251), 1);
    @(negedge clk);
    chk("cont_end_busy", bsy0, 0);
    chk("cont_end_ro_en", en0, 0);
    wait_mv(0, 1100, n_mv);
    chk("cont_end_no_valid", n_mv, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
